linear_tile_sched: RTL and testbench

//  Sequences the 8x8 systolic linear engine over a multi-tile job.

---
 rtl/linear_tile_sched.sv | 139 +++++++++++++
 tb/tb_linear_tile_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linear_tile_sched.sv
`default_nettype none
// ============================================================================
//  Module   : linear_tile_sched
//  Brief    : Issues one engine start per tile of a job, with inter-tile gap,
//             per-tile watchdog, host abort and job-completion pulse.
//  Revision : 1.0  initial release
// ============================================================================
module linear_tile_sched #(
    parameter int TILE_W     = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1024,
    parameter int TMR_W      = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [TILE_W-1:0] cmd_tiles_i,
    input  logic              cmd_abort_i,
    output logic              eng_start_o,
    input  logic              eng_done_i,
    output logic [TILE_W-1:0] tile_idx_o,
    output logic              busy_o,
    output logic              job_done_o,
    output logic              err_timeout_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TILE_W-1:0] TILE_ONE = TILE_W'(1);

    logic [2:0]        state_q, state_d;
    logic [TILE_W-1:0] tiles_q, tiles_d;
    logic [TILE_W-1:0] idx_q,   idx_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [GAP_W-1:0]  gap_q,   gap_d;

    always_comb begin
        state_d = state_q;
        tiles_d = tiles_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    tiles_d = cmd_tiles_i;
                    idx_d   = '0;
                    state_d = (cmd_tiles_i != '0) ? ST_START : ST_FIN;
                end
            end
            ST_START: begin
                if (cmd_abort_i) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                timer_d = timer_q + TMR_W'(1);
                // Abort outranks done, and done outranks the watchdog
                if (cmd_abort_i) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else if (eng_done_i) begin
                    if (idx_q == tiles_q - TILE_ONE) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + TILE_ONE;
                        state_d = (GAP_CYCLES == 0) ? ST_START : ST_GAP;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_GAP: begin
                if (cmd_abort_i) begin
                    idx_d   = '0;
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_START;
                end else begin
                    gap_d   = gap_q + GAP_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (cmd_abort_i) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                idx_d   = '0;
                gap_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tiles_q <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            tiles_q <= tiles_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
        end
    end

    assign cmd_ready_o   = (state_q == ST_IDLE);
    assign eng_start_o   = (state_q == ST_START);
    assign busy_o        = (state_q == ST_START) || (state_q == ST_RUN) || (state_q == ST_GAP);
    assign job_done_o    = (state_q == ST_FIN);
    assign err_timeout_o = (state_q == ST_ERR);
    assign tile_idx_o    = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_linear_tile_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_linear_tile_sched
//  Brief    : Self-checking bench for linear_tile_sched with a timeline model
//             of start/done/job_done cycles and a reactive engine stub.
//  Revision : 1.0  initial release
// ============================================================================
module tb_linear_tile_sched;

    localparam int TILE_W = 8;
    localparam int GAP    = 2;
    localparam int TMO    = 16;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [TILE_W-1:0] cmd_tiles_i;
    logic              cmd_abort_i;
    logic              eng_start_o;
    logic              eng_done_i;
    logic [TILE_W-1:0] tile_idx_o;
    logic              busy_o;
    logic              job_done_o;
    logic              err_timeout_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    linear_tile_sched #(
        .TILE_W    (TILE_W),
        .GAP_CYCLES(GAP),
        .TIMEOUT   (TMO),
        .TMR_W     (11)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_tiles_i  (cmd_tiles_i),
        .cmd_abort_i  (cmd_abort_i),
        .eng_start_o  (eng_start_o),
        .eng_done_i   (eng_done_i),
        .tile_idx_o   (tile_idx_o),
        .busy_o       (busy_o),
        .job_done_o   (job_done_o),
        .err_timeout_o(err_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: start0 = accept+1; next start = done+GAP+1; job_done = last done+1.
    task automatic run_job(input int n, input int lat_lo, input int lat_hi,
                           input int hold_next, input string name);
        int a, c, k, next_start, done_at, jd_at;
        int lats[$];
        bit ended, exp_start, exp_busy, exp_ready;
        for (int i = 0; i < n; i++) lats.push_back(int'($urandom_range(lat_hi, lat_lo)));
        a = cyc; k = 0; next_start = a + 1; done_at = -1; ended = 1'b0;
        jd_at = (n == 0) ? a + 1 : -1;
        for (int it = 0; it < 3000 && !ended; it++) begin
            c = cyc;
            exp_start = (k < n) && (c == next_start);
            if (exp_start) done_at = c + lats[k];
            total++;
            if (eng_start_o !== exp_start) begin
                bad++; $display("FAIL %s start cyc=%0d got=%b exp=%b", name, c - a, eng_start_o, exp_start);
            end
            if (exp_start) begin
                total++;
                if (tile_idx_o !== TILE_W'(k)) begin
                    bad++; $display("FAIL %s tile_idx got=%0d exp=%0d", name, tile_idx_o, k);
                end
            end
            total++;
            if (job_done_o !== (jd_at >= 0 && c == jd_at)) begin
                bad++; $display("FAIL %s job_done cyc=%0d got=%b exp=%b", name, c - a, job_done_o, (jd_at >= 0 && c == jd_at));
            end
            exp_busy  = (c > a) && (jd_at < 0 || c < jd_at);
            exp_ready = (c <= a) || (jd_at >= 0 && c > jd_at);
            total++;
            if (busy_o !== exp_busy) begin
                bad++; $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, c - a, busy_o, exp_busy);
            end
            total++;
            if (cmd_ready_o !== exp_ready) begin
                bad++; $display("FAIL %s cmd_ready cyc=%0d got=%b exp=%b", name, c - a, cmd_ready_o, exp_ready);
            end
            total++;
            if (err_timeout_o !== 1'b0) begin
                bad++; $display("FAIL %s err_timeout cyc=%0d got=%b exp=0", name, c - a, err_timeout_o);
            end
            eng_done_i = (c == done_at);
            if (c == done_at) begin
                k++;
                if (k == n) jd_at = c + 1;
                else        next_start = c + GAP + 1;
            end
            cmd_valid_i = (c == a) || (hold_next >= 0);
            cmd_tiles_i = (c == a) ? TILE_W'(n) : ((hold_next >= 0) ? TILE_W'(hold_next) : TILE_W'($urandom));
            if (jd_at >= 0 && c == jd_at + 1) ended = 1'b1;
            else                              step();
        end
        eng_done_i = 1'b0;
        total++;
        if (!ended) begin
            bad++; $display("FAIL %s budget got=expired exp=job_done", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL reset cmd_ready got=%b exp=1", cmd_ready_o); end
        total++; if (eng_start_o !== 1'b0) begin bad++; $display("FAIL reset eng_start got=%b exp=0", eng_start_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy_o); end
        total++; if (job_done_o !== 1'b0) begin bad++; $display("FAIL reset job_done got=%b exp=0", job_done_o); end
        total++; if (err_timeout_o !== 1'b0) begin bad++; $display("FAIL reset err got=%b exp=0", err_timeout_o); end
        total++; if (tile_idx_o !== '0) begin bad++; $display("FAIL reset tile_idx got=%0d exp=0", tile_idx_o); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_timeout();
        int a, c;
        a = cyc;
        for (int it = 0; it < 26; it++) begin
            c = cyc;
            total++;
            if (err_timeout_o !== (c >= a + TMO + 2)) begin
                bad++; $display("FAIL timeout err cyc=%0d got=%b exp=%b", c - a, err_timeout_o, (c >= a + TMO + 2));
            end
            total++;
            if (busy_o !== (c >= a + 1 && c <= a + TMO + 1)) begin
                bad++; $display("FAIL timeout busy cyc=%0d got=%b", c - a, busy_o);
            end
            total++;
            if (cmd_ready_o !== (c <= a)) begin
                bad++; $display("FAIL timeout cmd_ready cyc=%0d got=%b exp=%b", c - a, cmd_ready_o, (c <= a));
            end
            total++;
            if (eng_start_o !== (c == a + 1)) begin
                bad++; $display("FAIL timeout start cyc=%0d got=%b", c - a, eng_start_o);
            end
            cmd_valid_i = (c == a);
            cmd_tiles_i = 8'd2;
            step();
        end
        cmd_abort_i = 1'b1;
        step();
        cmd_abort_i = 1'b0;
        total++; if (err_timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_abort err got=%b exp=0", err_timeout_o); end
        total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL timeout_abort cmd_ready got=%b exp=1", cmd_ready_o); end
        total++; if (tile_idx_o !== '0) begin bad++; $display("FAIL timeout_abort tile_idx got=%0d exp=0", tile_idx_o); end
    endtask

    task automatic test_abort_gap();
        int a, c;
        a = cyc;
        for (int it = 0; it < 21; it++) begin
            c = cyc;
            total++;
            if (eng_start_o !== (c == a + 1)) begin
                bad++; $display("FAIL abort_gap start cyc=%0d got=%b", c - a, eng_start_o);
            end
            total++;
            if (job_done_o !== 1'b0) begin
                bad++; $display("FAIL abort_gap job_done cyc=%0d got=%b exp=0", c - a, job_done_o);
            end
            total++;
            if (cmd_ready_o !== (c <= a || c >= a + 6)) begin
                bad++; $display("FAIL abort_gap cmd_ready cyc=%0d got=%b", c - a, cmd_ready_o);
            end
            total++;
            if (busy_o !== (c >= a + 1 && c <= a + 5)) begin
                bad++; $display("FAIL abort_gap busy cyc=%0d got=%b", c - a, busy_o);
            end
            if (c >= a + 5) begin
                total++;
                if (tile_idx_o !== ((c == a + 5) ? 8'd1 : 8'd0)) begin
                    bad++; $display("FAIL abort_gap tile_idx cyc=%0d got=%0d", c - a, tile_idx_o);
                end
            end
            cmd_valid_i = (c == a);
            cmd_tiles_i = 8'd4;
            eng_done_i  = (c == a + 4) || (c == a + 12);
            cmd_abort_i = (c == a + 5);
            step();
        end
        eng_done_i  = 1'b0;
        cmd_abort_i = 1'b0;
    endtask

    task automatic test_abort_done();
        int a, c;
        a = cyc;
        for (int it = 0; it < 15; it++) begin
            c = cyc;
            total++;
            if (job_done_o !== 1'b0) begin
                bad++; $display("FAIL abort_done job_done cyc=%0d got=%b exp=0", c - a, job_done_o);
            end
            total++;
            if (eng_start_o !== (c == a + 1)) begin
                bad++; $display("FAIL abort_done start cyc=%0d got=%b", c - a, eng_start_o);
            end
            total++;
            if (cmd_ready_o !== (c <= a || c >= a + 6)) begin
                bad++; $display("FAIL abort_done cmd_ready cyc=%0d got=%b", c - a, cmd_ready_o);
            end
            cmd_valid_i = (c == a);
            cmd_tiles_i = 8'd1;
            eng_done_i  = (c == a + 5) || (c == a + 9);
            cmd_abort_i = (c == a + 5);
            step();
        end
        eng_done_i  = 1'b0;
        cmd_abort_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_job(2, 1, 4, 1, "b2b_first");
        run_job(1, 1, 4, -1, "b2b_second");
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++)
            run_job(int'($urandom_range(5, 0)), 1, 9, -1, "random");
    endtask

    task automatic test_reset_mid_run();
        cmd_valid_i = 1'b1;
        cmd_tiles_i = 8'd3;
        step();
        cmd_valid_i = 1'b0;
        step();
        eng_done_i = 1'b1;
        step();
        eng_done_i = 1'b0;
        repeat (5) step();
        total++; if (busy_o !== 1'b1 || tile_idx_o !== 8'd1) begin
            bad++; $display("FAIL mid_run pre busy=%b tile_idx=%0d exp busy=1 tile_idx=1", busy_o, tile_idx_o);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL mid_reset cmd_ready got=%b exp=1", cmd_ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_reset busy got=%b exp=0", busy_o); end
        total++; if (tile_idx_o !== '0) begin bad++; $display("FAIL mid_reset tile_idx got=%0d exp=0", tile_idx_o); end
        total++; if (eng_start_o !== 1'b0 || job_done_o !== 1'b0 || err_timeout_o !== 1'b0) begin
            bad++; $display("FAIL mid_reset pulses got=%b%b%b exp=000", eng_start_o, job_done_o, err_timeout_o);
        end
        step();
        rst_n = 1'b1;
        step();
        run_job(2, 1, 3, -1, "after_reset");
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_tiles_i = '0;
        cmd_abort_i = 1'b0;
        eng_done_i  = 1'b0;
        test_reset();
        run_job(3, 5, 5, -1, "basic");
        run_job(0, 1, 1, -1, "zero_tiles");
        test_timeout();
        test_abort_gap();
        test_abort_done();
        test_back_to_back();
        run_job(1, TMO, TMO, -1, "done_at_expiry");
        test_random();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
